// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, class bit indices, decoded-entry type.
// Imported by decode_comb, decode_stage and decode_stage_if.
package decode_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int TYPE_W = 10;

    localparam int T_R      = 0;
    localparam int T_I      = 1;
    localparam int T_LOAD   = 2;
    localparam int T_STORE  = 3;
    localparam int T_BRANCH = 4;
    localparam int T_JAL    = 5;
    localparam int T_JALR   = 6;
    localparam int T_LUI    = 7;
    localparam int T_AUIPC  = 8;
    localparam int T_SYS    = 9;

    // Decoded view of one instruction. The immediate is kept at its
    // native 32-bit signed width; the stage sign-extends it to XLEN.
    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic              illegal;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [31:0]       imm;
    } dec_t;

    function automatic logic [TYPE_W-1:0] tbit(input int idx);
        logic [TYPE_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bundle for decode_stage: fetch-side input, decoded output
// and debug counters. slave = the stage, master = its environment.
interface decode_stage_if
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [TYPE_W-1:0] out_type;
    logic              out_illegal;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [XLEN-1:0]   out_imm;
    logic [CNT_W-1:0]  dec_count;
    logic [CNT_W-1:0]  illegal_count;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_type,
        output out_illegal, out_rd, out_rs1, out_rs2,
        output out_funct3, out_funct7, out_imm,
        output dec_count, illegal_count
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_type,
        input  out_illegal, out_rd, out_rs1, out_rs2,
        input  out_funct3, out_funct7, out_imm,
        input  dec_count, illegal_count
    );

endinterface

// File: rtl/decode_comb.sv
// Combinational RV32I decoder: raw instruction to dec_t.
// FENCE/ECALL/EBREAK are decoded only when DECODE_SYSTEM_EN is defined.
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [31:0]       imm_i;
    logic [31:0]       imm_s;
    logic [31:0]       imm_b;
    logic [31:0]       imm_u;
    logic [31:0]       imm_j;
    logic [TYPE_W-1:0] typ;
    logic [31:0]       imm;
    logic              legal;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    // Class, format and legality per opcode; non-11 low bits miss every arm.
    always_comb begin
        typ   = '0;
        imm   = '0;
        legal = 1'b0;
        unique case (opc)
            OPC_R: begin
                typ   = tbit(T_R);
                legal = (f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 &&
                         (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_I: begin
                typ = tbit(T_I);
                imm = imm_i;
                unique case (f3)
                    3'b001:  legal = (f7 == 7'b0000000);
                    3'b101:  legal = (f7 == 7'b0000000) ||
                                     (f7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                typ   = tbit(T_LOAD);
                imm   = imm_i;
                legal = (f3 inside {3'b000, 3'b001, 3'b010,
                                    3'b100, 3'b101});
            end
            OPC_STORE: begin
                typ   = tbit(T_STORE);
                imm   = imm_s;
                legal = (f3 inside {3'b000, 3'b001, 3'b010});
            end
            OPC_BRANCH: begin
                typ   = tbit(T_BRANCH);
                imm   = imm_b;
                legal = !(f3 inside {3'b010, 3'b011});
            end
            OPC_JAL: begin
                typ   = tbit(T_JAL);
                imm   = imm_j;
                legal = 1'b1;
            end
            OPC_JALR: begin
                typ   = tbit(T_JALR);
                imm   = imm_i;
                legal = (f3 == 3'b000);
            end
            OPC_LUI: begin
                typ   = tbit(T_LUI);
                imm   = imm_u;
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                typ   = tbit(T_AUIPC);
                imm   = imm_u;
                legal = 1'b1;
            end
`ifdef DECODE_SYSTEM_EN
            OPC_FENCE: begin
                typ   = tbit(T_SYS);
                legal = (f3 == 3'b000);
            end
            OPC_SYSTEM: begin
                typ   = tbit(T_SYS);
                legal = (instr == 32'h0000_0073) ||
                        (instr == 32'h0010_0073);
            end
`else
            OPC_FENCE,
            OPC_SYSTEM: legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
    end

    // Illegal entries report no class and no immediate, only raw fields.
    always_comb begin
        dec.typ     = legal ? typ : '0;
        dec.imm     = legal ? imm : '0;
        dec.illegal = !legal;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = f3;
        dec.funct7  = f7;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry skid buffer and saturating
// debug counters. Optional system decode: define DECODE_SYSTEM_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    input logic flush,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        dec_t            dec;
    } entry_t;

    dec_t   in_dec;
    entry_t in_ent;

    entry_t           main_q,     main_d;
    logic             main_vld_q, main_vld_d;
    entry_t           skid_q,     skid_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] dec_cnt_q,  dec_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q,  ill_cnt_d;

    logic in_hs;
    logic out_hs;

    decode_comb u_comb (
        .instr (bus.in_instr),
        .dec   (in_dec)
    );

    assign in_ent = '{pc: bus.in_pc, dec: in_dec};
    assign in_hs  = bus.in_valid & in_ready_q;
    assign out_hs = main_vld_q & bus.out_ready;

    // Buffer steering: main refills from skid first, then from the input.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_hs) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = in_hs;
                if (in_hs) begin
                    main_d = in_ent;
                end
            end
        end else if (in_hs) begin
            skid_d     = in_ent;
            skid_vld_d = 1'b1;
        end
        in_ready_d = !skid_vld_d;
    end

    // Saturating counters; a handshake during flush still counts.
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        ill_cnt_d = ill_cnt_q;
        if (out_hs && dec_cnt_q != '1) begin
            dec_cnt_d = dec_cnt_q + CNT_W'(1);
        end
        if (out_hs && main_q.dec.illegal && ill_cnt_q != '1) begin
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
            dec_cnt_q  <= '0;
            ill_cnt_q  <= '0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            dec_cnt_q  <= dec_cnt_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = main_vld_q;
    assign bus.out_pc        = main_q.pc;
    assign bus.out_type      = main_q.dec.typ;
    assign bus.out_illegal   = main_q.dec.illegal;
    assign bus.out_rd        = main_q.dec.rd;
    assign bus.out_rs1       = main_q.dec.rs1;
    assign bus.out_rs2       = main_q.dec.rs2;
    assign bus.out_funct3    = main_q.dec.funct3;
    assign bus.out_funct7    = main_q.dec.funct7;
    assign bus.out_imm       = XLEN'(signed'(main_q.dec.imm));
    assign bus.dec_count     = dec_cnt_q;
    assign bus.illegal_count = ill_cnt_q;

endmodule
